// File: rtl/rf_pkg.sv
// Shared constants for the register-file write path: default widths,
// one-hot grant encodings and the hard-wired zero register number.
package rf_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req and the stored
// last-granted index, which updates on the edge when advance is high.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_0;
      2'b10:   gnt = GNT_1;
      2'b11:   gnt = last ? GNT_0 : GNT_1;
      default: gnt = GNT_NONE;
    endcase
  end

  // last resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (gnt != GNT_NONE)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the rf write port between two writeback requesters through one-entry
// holding buffers, granting one buffered write per cycle in round-robin order.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int ZERO_DROP = 1,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_wn,
  input  logic [DW-1:0] req0_wd,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_wn,
  input  logic [DW-1:0] req1_wd,
  output logic          rf_w,
  output logic [AW-1:0] rf_wn,
  output logic [DW-1:0] rf_wd,
  output logic [1:0]    grant,
  output logic [CW-1:0] conflicts
);

  logic [1:0]    buf_v;
  logic [AW-1:0] buf_wn [2];
  logic [DW-1:0] buf_wd [2];

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (buf_v),
    .advance (grant != GNT_NONE),
    .gnt     (grant)
  );

  always_comb begin
    rf_wn = '0;
    rf_wd = '0;
    if (grant[0]) begin
      rf_wn = buf_wn[0];
      rf_wd = buf_wd[0];
    end else if (grant[1]) begin
      rf_wn = buf_wn[1];
      rf_wd = buf_wd[1];
    end
  end

  // A write to register 0 still consumes its grant; it just never reaches the rf.
  assign rf_w = (grant != GNT_NONE) && !((ZERO_DROP != 0) && (rf_wn == AW'(REG_ZERO)));

  // A buffer draining this cycle can refill on the same edge.
  assign req0_ready = !buf_v[0] || grant[0];
  assign req1_ready = !buf_v[1] || grant[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_v     <= 2'b00;
      buf_wn[0] <= '0;
      buf_wn[1] <= '0;
      buf_wd[0] <= '0;
      buf_wd[1] <= '0;
    end else begin
      if (req0_valid && req0_ready) begin
        buf_v[0]  <= 1'b1;
        buf_wn[0] <= req0_wn;
        buf_wd[0] <= req0_wd;
      end else if (grant[0]) begin
        buf_v[0] <= 1'b0;
      end
      if (req1_valid && req1_ready) begin
        buf_v[1]  <= 1'b1;
        buf_wn[1] <= req1_wn;
        buf_wd[1] <= req1_wd;
      end else if (grant[1]) begin
        buf_v[1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflicts <= '0;
    end else if ((&buf_v) && (conflicts != {CW{1'b1}})) begin
      conflicts <= conflicts + 1'b1;
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (w, wn, wd) between two writeback requesters: req0 (ALU result) and req1 (memory load data).
- Each requester has a valid/ready handshake into a one-entry holding buffer.
- The arbiter grants one buffered write per cycle using round-robin priority and drives the rf write port.
- It sits between the execute/memory stages and the rf instance. The rf read ports are untouched.

Parameters:
- DW, 32, data width; matches rf wd.
- AW, 5, register-number width; matches rf wn.
- ZERO_DROP, 1, when 1 a write targeting register 0 is consumed but never drives rf_w.
- CW, 16, width of the conflict counter.

Ports:
- clk  input  1  rising-edge clock; same clock as rf.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 presents a write.
- req0_ready  output  1  requester 0 write accepted this edge when valid&ready.
- req0_wn  input  AW  requester 0 destination register.
- req0_wd  input  DW  requester 0 data.
- req1_valid  input  1  requester 1 presents a write.
- req1_ready  output  1  requester 1 write accepted this edge when valid&ready.
- req1_wn  input  AW  requester 1 destination register.
- req1_wd  input  DW  requester 1 data.
- rf_w  output  1  write enable to rf.
- rf_wn  output  AW  write register number to rf.
- rf_wd  output  DW  write data to rf.
- grant  output  2  one-hot grant of the current cycle; 2'b00 when idle.
- conflicts  output  CW  count of cycles in which both buffers were valid; saturates at all-ones.

Behaviour:
- State per requester i:
  - buf_v[i], buf_wn[i], buf_wd[i].
  - Round-robin pointer last: 0 or 1, the index granted most recently.
- Reset (asynchronous, any time, including mid-transfer):
  - buf_v cleared; last=1, so req0 has priority on the first contention.
  - conflicts=0.
  - Outputs become rf_w=0, rf_wn=0, rf_wd=0, grant=0. Buffered data is discarded.
- Grant (combinational from registered state):
  - Only one buffer valid: grant it.
  - Both valid: grant index !last.
  - None valid: grant=0.
- Write port outputs:
  - rf_wn and rf_wd come from the granted buffer; 0 when idle.
  - rf_w=1 when a grant exists, except rf_w=0 when ZERO_DROP=1 and granted wn==0.
- Clock edge:
  - The granted buffer clears; last updates to the granted index.
  - The rf samples rf_w/rf_wn/rf_wd on the same edge.
- Ready: req_i_ready = !buf_v[i] | grant[i], combinational.
  - A buffer granted this cycle accepts a new write on the same edge, giving full throughput for one requester.
- Accept: on an edge with req_i_valid & req_i_ready, buf_i loads wn/wd and buf_v[i]=1.
  - A load takes precedence over the clear of the same buffer.
- Latency: accepted at edge N; written to rf at edge N+1 if uncontended, N+2 if it loses one arbitration. Worst case is 2 cycles.
- Sustained contention alternates 0,1,0,1; neither requester starves.
- Same wn in both buffers:
  - Both writes issue in grant order; the later grant's data is final in rf.
  - Upstream must order dependent writes; the arbiter does no merging.
- Conflict counter:
  - conflicts increments on an edge where buf_v[0]&buf_v[1], unless already all-ones.
- Inputs are don't-care when valid=0. valid may drop without ready; nothing is captured.

Decomposition:
- Shared package rf_pkg:
  - AW/DW defaults.
  - Localparams for grant encodings GNT_NONE=2'b00, GNT_0=2'b01, GNT_1=2'b10.
  - REG_ZERO=0.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter holding the last pointer. It has inputs req[1:0] and advance, and output gnt[1:0].
- Holding buffers stay in the top module.

Test Plan:
- Reset, then req0 writes wn=1, wd=32'h2EA7ABDD at edge 1 → edge 2 has rf_w=1, rf_wn=1, grant=01. A later rf read of rn1=1 returns 32'h2EA7ABDD.
- req0 (wn=2, wd=5) and req1 (wn=3, wd=7) accepted on the same edge:
  - First grant is 01, then 10; both rf writes land on consecutive edges.
  - conflicts=1 afterwards.
- Both held valid for 8 writes each → grants alternate 01,10,... with no repeats; all 16 writes reach the rf; rf holds the last data per register.
- req1 writes wn=0, wd=9 with ZERO_DROP=1 → buffer consumed (req1_ready returns high), grant=10, rf_w stays 0; rn1=0 still reads 0.
- req0 streams 32 writes wn=i, wd=i*i back-to-back → req0_ready is never low after the first accept; rf reg i holds i*i (reg 0 holds 0).
- Assert reset while both buffers are valid → the pending writes never reach the rf; rf_w=0, conflicts=0, and req0 is granted first on the next contention.
